// File: rtl/toy_backup_rename_map_ctrl_pkg.sv
// Shared types and widths for the committed rename map and its recovery sequencer.
package toy_backup_rename_map_ctrl_pkg;

  // Every module that carries a commit payload uses these geometry values.
  localparam int ARCH_NUM_P = 32;
  localparam int PHY_NUM_P  = 128;
  localparam int ARCH_W     = $clog2(ARCH_NUM_P);
  localparam int PHY_W      = $clog2(PHY_NUM_P);

  // One commit channel's payload.
  typedef struct packed {
    logic [ARCH_W-1:0] arch_reg_index;
    logic [PHY_W-1:0]  phy_reg_index;
    logic              rd_en;
    logic              fp_rd_en;
  } commit_pkg;

  // Recovery sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DONE    = 2'd2
  } rec_state_e;

  // In INT mode architectural register 0 is hard-wired and never remapped.
  function automatic logic arch_is_writable(input int mode, input logic [ARCH_W-1:0] arch);
    return (mode != 0) || (arch != '0);
  endfunction

endpackage

// File: rtl/toy_backup_rename_map_wsel.sv
// Per-arch-entry write select: for every architectural entry, pick the youngest
// (highest-index) commit channel that writes it this cycle.
module toy_backup_rename_map_wsel
  import toy_backup_rename_map_ctrl_pkg::*;
#(
  parameter int COMMIT_CH = 4,
  parameter int ARCH_NUM  = ARCH_NUM_P
) (
  input  logic [COMMIT_CH-1:0]             ch_wen_i,
  input  logic [COMMIT_CH-1:0][ARCH_W-1:0] ch_arch_i,
  input  logic [COMMIT_CH-1:0][PHY_W-1:0]  ch_phy_i,
  output logic [ARCH_NUM-1:0]              entry_wen_o,
  output logic [ARCH_NUM-1:0][PHY_W-1:0]   entry_phy_o
);

  // Ascending channel scan: a later (younger) match overrides an earlier one.
  always_comb begin
    entry_wen_o = '0;
    entry_phy_o = '0;
    for (int j = 0; j < ARCH_NUM; j++) begin
      for (int i = 0; i < COMMIT_CH; i++) begin
        if (ch_wen_i[i] && (ch_arch_i[i] == ARCH_W'(j))) begin
          entry_wen_o[j] = 1'b1;
          entry_phy_o[j] = ch_phy_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/toy_backup_rename_map_ctrl.sv
// Committed (architectural) rename map. Applies commits, reports freed /
// newly referenced / same-cycle-superseded physical registers to the free
// list, and on flush streams the committed map back RECOV_LANES entries a beat.
module toy_backup_rename_map_ctrl
  import toy_backup_rename_map_ctrl_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int COMMIT_CH   = 4,
  parameter int ARCH_NUM    = ARCH_NUM_P,
  parameter int PHY_NUM     = PHY_NUM_P,
  parameter int RECOV_LANES = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COMMIT_CH-1:0]                 v_commit_en,
  input  commit_pkg [COMMIT_CH-1:0]            v_commit_pld,
  output logic                                 commit_rdy,
  input  logic                                 flush_req,
  output logic [ARCH_NUM-1:0][PHY_W-1:0]       v_map_phy_id,
  output logic [PHY_NUM-1:0]                   v_phy_release,
  output logic [PHY_NUM-1:0]                   v_phy_back_ref,
  output logic [PHY_NUM-1:0]                   v_phy_release_comb,
  output logic                                 rec_vld,
  output logic [ARCH_W-1:0]                    rec_base,
  output logic [RECOV_LANES-1:0][PHY_W-1:0]    v_rec_phy_id,
  output logic                                 rec_done
);

  localparam int NBEATS = ARCH_NUM / RECOV_LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  logic [COMMIT_CH-1:0]             ch_wen;
  logic [COMMIT_CH-1:0][ARCH_W-1:0] ch_arch;
  logic [COMMIT_CH-1:0][PHY_W-1:0]  ch_phy;
  logic [ARCH_NUM-1:0]              entry_wen;
  logic [ARCH_NUM-1:0][PHY_W-1:0]   entry_phy;

  logic [ARCH_NUM-1:0][PHY_W-1:0]   map_q;
  logic [PHY_NUM-1:0]               rel_d, rel_q;
  logic [PHY_NUM-1:0]               back_d, back_q;
  logic [PHY_NUM-1:0]               comb_d, comb_q;

  rec_state_e                       state_q, state_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;

  // Per-channel write enable; commits are only honoured while the sequencer is idle.
  always_comb begin
    ch_wen  = '0;
    ch_arch = '0;
    ch_phy  = '0;
    for (int i = 0; i < COMMIT_CH; i++) begin
      ch_arch[i] = v_commit_pld[i].arch_reg_index;
      ch_phy[i]  = v_commit_pld[i].phy_reg_index;
      ch_wen[i]  = v_commit_en[i] & commit_rdy &
                   ((MODE != 0) ? v_commit_pld[i].fp_rd_en : v_commit_pld[i].rd_en) &
                   arch_is_writable(MODE, v_commit_pld[i].arch_reg_index);
    end
  end

  toy_backup_rename_map_wsel #(
    .COMMIT_CH (COMMIT_CH),
    .ARCH_NUM  (ARCH_NUM)
  ) u_wsel (
    .ch_wen_i    (ch_wen),
    .ch_arch_i   (ch_arch),
    .ch_phy_i    (ch_phy),
    .entry_wen_o (entry_wen),
    .entry_phy_o (entry_phy)
  );

  // Committed map: identity out of reset, youngest channel wins per entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < ARCH_NUM; j++) map_q[j] <= PHY_W'(j);
    end else begin
      for (int j = 0; j < ARCH_NUM; j++) begin
        if (entry_wen[j]) map_q[j] <= entry_phy[j];
      end
    end
  end

  // Free-list vectors: old mapping of each written entry is released once;
  // older same-entry commits in the cycle are superseded before they land.
  always_comb begin
    logic superseded;
    rel_d      = '0;
    back_d     = '0;
    comb_d     = '0;
    superseded = 1'b0;
    for (int j = 0; j < ARCH_NUM; j++) begin
      if (entry_wen[j]) rel_d[map_q[j]] = 1'b1;
    end
    for (int i = 0; i < COMMIT_CH; i++) begin
      superseded = 1'b0;
      for (int k = i + 1; k < COMMIT_CH; k++) begin
        if (ch_wen[k] && (ch_arch[k] == ch_arch[i])) superseded = 1'b1;
      end
      if (ch_wen[i]) begin
        back_d[ch_phy[i]] = 1'b1;
        if (superseded) comb_d[ch_phy[i]] = 1'b1;
      end
    end
  end

  // Register the free-list vectors; they read zero in cycles without commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_q  <= '0;
      back_q <= '0;
      comb_q <= '0;
    end else begin
      rel_q  <= rel_d;
      back_q <= back_d;
      comb_q <= comb_d;
    end
  end

  assign v_map_phy_id       = map_q;
  assign v_phy_release      = rel_q;
  assign v_phy_back_ref     = back_q;
  assign v_phy_release_comb = comb_q;

  // Recovery FSM state and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Recovery next state: a flush always (re)starts at beat 0.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = RESTORE;
          beat_d  = '0;
        end
      end
      RESTORE: begin
        if (flush_req) begin
          beat_d = '0;
        end else if (beat_q == LAST_BEAT) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        state_d = flush_req ? RESTORE : IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Recovery outputs decoded from the current state; lanes read the live map.
  always_comb begin
    commit_rdy   = (state_q == IDLE);
    rec_vld      = (state_q == RESTORE);
    rec_done     = (state_q == DONE);
    rec_base     = ARCH_W'(int'(beat_q) * RECOV_LANES);
    v_rec_phy_id = '0;
    for (int l = 0; l < RECOV_LANES; l++) begin
      v_rec_phy_id[l] = map_q[rec_base + ARCH_W'(l)];
    end
  end

endmodule

// File: tb/tb_toy_backup_rename_map_ctrl.sv
// Self-checking bench for the committed rename map and recovery sequencer.
module tb_toy_backup_rename_map_ctrl;
  import toy_backup_rename_map_ctrl_pkg::*;

  localparam int CH = 4;
  localparam int AN = 32;
  localparam int PN = 128;
  localparam int LN = 8;
  localparam int NB = AN / LN;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [CH-1:0]              en;
  commit_pkg [CH-1:0]         pld;
  logic                       rdy;
  logic                       flush;
  logic [AN-1:0][PHY_W-1:0]   map_o;
  logic [PN-1:0]              rel_o, back_o, comb_o;
  logic                       rec_vld;
  logic [ARCH_W-1:0]          rec_base;
  logic [LN-1:0][PHY_W-1:0]   lanes_o;
  logic                       rec_done;

  always #5 clk = ~clk;

  toy_backup_rename_map_ctrl #(
    .MODE(0), .COMMIT_CH(CH), .ARCH_NUM(AN), .PHY_NUM(PN), .RECOV_LANES(LN)
  ) dut (
    .clk(clk), .rst(rst), .v_commit_en(en), .v_commit_pld(pld), .commit_rdy(rdy),
    .flush_req(flush), .v_map_phy_id(map_o), .v_phy_release(rel_o),
    .v_phy_back_ref(back_o), .v_phy_release_comb(comb_o), .rec_vld(rec_vld),
    .rec_base(rec_base), .v_rec_phy_id(lanes_o), .rec_done(rec_done)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference model: map as plain ints, recovery as a position
  // (-1 idle, 0..NB-1 beat index, NB done cycle).
  int            map_m[AN];
  int            pos_m;
  logic [PN-1:0] rel_e, back_e, comb_e;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < AN; j++) map_m[j] = j;
    pos_m  = -1;
    rel_e  = '0;
    back_e = '0;
    comb_e = '0;
  endtask

  task automatic check_all();
    logic [AN-1:0][PHY_W-1:0] em;
    logic [LN-1:0][PHY_W-1:0] el;
    for (int j = 0; j < AN; j++) em[j] = PHY_W'(map_m[j]);
    chk("commit_rdy", rdy, (pos_m == -1));
    chk("map", map_o, em);
    chk("release", rel_o, rel_e);
    chk("back_ref", back_o, back_e);
    chk("release_comb", comb_o, comb_e);
    chk("rec_vld", rec_vld, (pos_m >= 0 && pos_m < NB));
    chk("rec_done", rec_done, (pos_m == NB));
    if (pos_m >= 0 && pos_m < NB) begin
      for (int l = 0; l < LN; l++) el[l] = PHY_W'(map_m[pos_m * LN + l]);
      chk("rec_base", rec_base, pos_m * LN);
      chk("rec_lanes", lanes_o, el);
    end
  endtask

  function automatic logic wen_m(input int i);
    return en[i] && pld[i].rd_en && (pld[i].arch_reg_index != '0);
  endfunction

  // Advance one clock: predict from the current inputs, then compare.
  task automatic step();
    int            nmap[AN];
    int            winner;
    int            npos;
    logic [PN-1:0] r, b, c;
    r = '0; b = '0; c = '0;
    nmap = map_m;
    if (pos_m == -1) begin
      for (int a = 0; a < AN; a++) begin
        winner = -1;
        for (int i = CH - 1; i >= 0; i--) begin
          if (wen_m(i) && int'(pld[i].arch_reg_index) == a) begin
            b[pld[i].phy_reg_index] = 1'b1;
            if (winner == -1) winner = i;
            else c[pld[i].phy_reg_index] = 1'b1;
          end
        end
        if (winner >= 0) begin
          r[map_m[a]] = 1'b1;
          nmap[a] = int'(pld[winner].phy_reg_index);
        end
      end
    end
    if (flush) npos = 0;
    else if (pos_m == -1) npos = -1;
    else if (pos_m >= NB) npos = -1;
    else npos = pos_m + 1;
    @(posedge clk);
    #1;
    step_no++;
    map_m  = nmap;
    pos_m  = npos;
    rel_e  = r;
    back_e = b;
    comb_e = c;
    check_all();
  endtask

  task automatic clear_in();
    en    = '0;
    pld   = '0;
    flush = 1'b0;
  endtask

  task automatic set_ch(input int i, input int arch, input int phy, input logic rd);
    en[i]                 = 1'b1;
    pld[i].arch_reg_index = ARCH_W'(arch);
    pld[i].phy_reg_index  = PHY_W'(phy);
    pld[i].rd_en          = rd;
    pld[i].fp_rd_en       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    step();

    // Single commit arch5 -> phy40, then an idle cycle.
    set_ch(0, 5, 40, 1'b1);
    step();
    clear_in();
    step();

    // Two channels on arch7: ch3 is youngest and wins.
    set_ch(0, 7, 50, 1'b1);
    set_ch(3, 7, 60, 1'b1);
    step();
    clear_in();
    step();

    // Arch 0 is hard-wired in INT mode.
    set_ch(0, 0, 90, 1'b1);
    step();
    clear_in();
    step();

    // Full recovery with a commit attempted while not ready.
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_ch(1, 9, 99, 1'b1);
    repeat (2) step();
    clear_in();
    repeat (3) step();

    // Commit and flush together; then restart on beat 2, then reset on beat 1.
    set_ch(2, 3, 77, 1'b1);
    flush = 1'b1;
    step();
    clear_in();
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    rst = 1'b0;
    step();

    // Flush during the DONE cycle goes straight back to beat 0.
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (5) step();

    // Randomized commits and flushes.
    repeat (400) begin
      for (int i = 0; i < CH; i++) begin
        en[i]                 = ($urandom_range(0, 3) != 0);
        pld[i].arch_reg_index = ($urandom_range(0, 1) == 0) ? ARCH_W'($urandom_range(0, 7))
                                                             : ARCH_W'($urandom_range(0, AN - 1));
        pld[i].phy_reg_index  = PHY_W'($urandom_range(0, PN - 1));
        pld[i].rd_en          = ($urandom_range(0, 4) != 0);
        pld[i].fp_rd_en       = 1'($urandom_range(0, 1));
      end
      flush = ($urandom_range(0, 24) == 0);
      step();
    end
    clear_in();
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
